// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared constants for the RV32I execute stage.
//   ALU_*        alu_ctrl operation codes
//   FWD_*        forwarding-unit select codes
//   JUMP_*       uncond_jump encodings
//   SEL_A_*      ALU operand A selects
//   SEL_B_*      ALU operand B selects
//   BR_*         branch funct3 codes
//   NOP_INST     instruction loaded into ID/EX on a flush (addi x0,x0,0)
package ex_stage_pkg;

  typedef logic [3:0] alu_ctrl_t;
  typedef logic [2:0] fwd_sel_t;
  typedef logic [1:0] jump_t;
  typedef logic [1:0] op_sel_t;
  typedef logic [2:0] br_funct3_t;

  localparam alu_ctrl_t ALU_ADD   = 4'd0;
  localparam alu_ctrl_t ALU_SUB   = 4'd1;
  localparam alu_ctrl_t ALU_SLL   = 4'd2;
  localparam alu_ctrl_t ALU_SLT   = 4'd3;
  localparam alu_ctrl_t ALU_SLTU  = 4'd4;
  localparam alu_ctrl_t ALU_XOR   = 4'd5;
  localparam alu_ctrl_t ALU_SRL   = 4'd6;
  localparam alu_ctrl_t ALU_SRA   = 4'd7;
  localparam alu_ctrl_t ALU_OR    = 4'd8;
  localparam alu_ctrl_t ALU_AND   = 4'd9;
  localparam alu_ctrl_t ALU_PASSB = 4'd10;

  localparam fwd_sel_t FWD_REG = 3'b000;
  localparam fwd_sel_t FWD_MEM = 3'b001;
  localparam fwd_sel_t FWD_WB  = 3'b010;

  localparam jump_t JUMP_NONE = 2'b00;
  localparam jump_t JUMP_JAL  = 2'b01;
  localparam jump_t JUMP_JALR = 2'b10;

  localparam op_sel_t SEL_A_RS1  = 2'd0;
  localparam op_sel_t SEL_A_PC   = 2'd1;
  localparam op_sel_t SEL_A_ZERO = 2'd2;

  localparam op_sel_t SEL_B_RS2  = 2'd0;
  localparam op_sel_t SEL_B_IMM  = 2'd1;
  localparam op_sel_t SEL_B_FOUR = 2'd2;

  localparam br_funct3_t BR_EQ  = 3'b000;
  localparam br_funct3_t BR_NE  = 3'b001;
  localparam br_funct3_t BR_LT  = 3'b100;
  localparam br_funct3_t BR_GE  = 3'b101;
  localparam br_funct3_t BR_LTU = 3'b110;
  localparam br_funct3_t BR_GEU = 3'b111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles every non-clock signal of the execute stage.
//   master : decode/forwarding/MEM-side view (drives ID inputs, reads results)
//   slave  : ex_stage view (reads ID inputs and forwarded data, drives
//            EX-stage indices, redirect requests and the EX/MEM register)
interface ex_stage_if #(
  parameter int INST_WIDTH          = 32,
  parameter int INST_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
);
  // decode-stage side
  logic                           flush_ID_EX;
  logic [INST_ADDR_WIDTH-1:0]     PC_ID;
  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_ID;
  logic [INST_WIDTH-1:0]          INST_ID;
  logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID;
  logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_ID;
  logic [DATA_WIDTH-1:0]          imm_ID;
  logic [DATA_WIDTH-1:0]          RD1D_ID;
  logic [DATA_WIDTH-1:0]          RD2D_ID;
  logic                           reg_write_ID;
  logic                           mem_write_ID;
  logic                           meet_branch_ID;
  logic                           pc_jal_sel_ID;
  logic [1:0]                     result_sel_ID;
  logic [1:0]                     uncond_jump_ID;
  logic [1:0]                     alu_sel_rs1_ID;
  logic [1:0]                     alu_sel_rs2_ID;
  logic [3:0]                     alu_ctrl_ID;
  logic [2:0]                     funct3_ID;
  // forwarding inputs
  logic [2:0]                     forward_detect_rs1;
  logic [2:0]                     forward_detect_rs2;
  logic [DATA_WIDTH-1:0]          alu_res_MEM;
  logic [DATA_WIDTH-1:0]          result_WB;
  // EX-stage observation and redirect
  logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX;
  logic [1:0]                     result_sel_EX;
  logic                           PC_take_branch_EX;
  logic                           PC_take_jalr_EX;
  logic [INST_ADDR_WIDTH-1:0]     PC_for_normal_branch_EX;
  logic [INST_ADDR_WIDTH-1:0]     PC_for_jalr_EX;
  // EX/MEM register
  logic [INST_WIDTH-1:0]          INST_MEM;
  logic                           reg_write_MEM;
  logic                           mem_write_MEM;
  logic [1:0]                     result_sel_MEM;
  logic [DATA_WIDTH-1:0]          alu_res_MEM_o;
  logic [DATA_WIDTH-1:0]          write_data_MEM;
  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_MEM;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_MEM;
  logic [2:0]                     funct3_MEM;

  modport master (
    output flush_ID_EX, PC_ID, PC_plus_4_ID, INST_ID, rs1_ID, rs2_ID, rd_ID,
           imm_ID, RD1D_ID, RD2D_ID, reg_write_ID, mem_write_ID,
           meet_branch_ID, pc_jal_sel_ID, result_sel_ID, uncond_jump_ID,
           alu_sel_rs1_ID, alu_sel_rs2_ID, alu_ctrl_ID, funct3_ID,
           forward_detect_rs1, forward_detect_rs2, alu_res_MEM, result_WB,
    input  rs1_EX, rs2_EX, rd_EX, result_sel_EX, PC_take_branch_EX,
           PC_take_jalr_EX, PC_for_normal_branch_EX, PC_for_jalr_EX,
           INST_MEM, reg_write_MEM, mem_write_MEM, result_sel_MEM,
           alu_res_MEM_o, write_data_MEM, PC_plus_4_MEM, rd_MEM, funct3_MEM
  );

  modport slave (
    input  flush_ID_EX, PC_ID, PC_plus_4_ID, INST_ID, rs1_ID, rs2_ID, rd_ID,
           imm_ID, RD1D_ID, RD2D_ID, reg_write_ID, mem_write_ID,
           meet_branch_ID, pc_jal_sel_ID, result_sel_ID, uncond_jump_ID,
           alu_sel_rs1_ID, alu_sel_rs2_ID, alu_ctrl_ID, funct3_ID,
           forward_detect_rs1, forward_detect_rs2, alu_res_MEM, result_WB,
    output rs1_EX, rs2_EX, rd_EX, result_sel_EX, PC_take_branch_EX,
           PC_take_jalr_EX, PC_for_normal_branch_EX, PC_for_jalr_EX,
           INST_MEM, reg_write_MEM, mem_write_MEM, result_sel_MEM,
           alu_res_MEM_o, write_data_MEM, PC_plus_4_MEM, rd_MEM, funct3_MEM
  );

endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational RV32I integer ALU.
//   op_a, op_b : operands
//   alu_ctrl   : operation (ALU_* codes); unknown codes yield 0
//   result     : wrapped DATA_WIDTH-bit result
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  alu_ctrl_t             alu_ctrl,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] op_a_s;
  logic signed [DATA_WIDTH-1:0] op_b_s;
  logic        [SHAMT_W-1:0]    shamt;

  assign op_a_s = op_a;
  assign op_b_s = op_b;
  assign shamt  = op_b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:   result = op_a + op_b;
      ALU_SUB:   result = op_a - op_b;
      ALU_SLL:   result = op_a << shamt;
      ALU_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, (op_a_s < op_b_s)};
      ALU_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:   result = op_a ^ op_b;
      ALU_SRL:   result = op_a >> shamt;
      ALU_SRA:   result = op_a_s >>> shamt;
      ALU_OR:    result = op_a | op_b;
      ALU_AND:   result = op_a & op_b;
      ALU_PASSB: result = op_b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RV32I pipeline.
//   cpu_clk : rising-edge clock
//   cpu_rst : asynchronous active-high reset, clears both pipeline registers
//   bus     : ex_stage_if.slave
//             in  - ID-stage fields, flush_ID_EX, forward selects and
//                   forwarded data (alu_res_MEM, result_WB)
//             out - EX-stage rs1/rs2/rd/result_sel, branch/JALR redirect
//                   requests and targets, EX/MEM register contents
// ID inputs reach the EX outputs after one edge, the MEM outputs after two.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int INST_WIDTH          = 32,
  parameter int INST_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5
) (
  input logic       cpu_clk,
  input logic       cpu_rst,
  ex_stage_if.slave bus
);

  // ID/EX register contents
  logic [INST_ADDR_WIDTH-1:0]     PC_EX;
  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX;
  logic [INST_WIDTH-1:0]          INST_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rs1_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rs2_EX;
  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX;
  logic [DATA_WIDTH-1:0]          imm_EX;
  logic [DATA_WIDTH-1:0]          RD1D_EX;
  logic [DATA_WIDTH-1:0]          RD2D_EX;
  logic                           reg_write_EX;
  logic                           mem_write_EX;
  logic                           meet_branch_EX;
  logic                           pc_jal_sel_EX;
  logic [1:0]                     result_sel_EX;
  jump_t                          uncond_jump_EX;
  op_sel_t                        alu_sel_rs1_EX;
  op_sel_t                        alu_sel_rs2_EX;
  alu_ctrl_t                      alu_ctrl_EX;
  logic [2:0]                     funct3_EX;

  // EX datapath
  logic [DATA_WIDTH-1:0] rs1_fwd;
  logic [DATA_WIDTH-1:0] rs2_fwd;
  logic [DATA_WIDTH-1:0] alu_op_a;
  logic [DATA_WIDTH-1:0] alu_op_b;
  logic [DATA_WIDTH-1:0] alu_res_EX;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic                  br_cond;

  // pc_jal_sel only rides along in ID/EX; EX has no use for it.
  logic unused_pc_jal_sel;
  assign unused_pc_jal_sel = pc_jal_sel_EX;

  // ---- ID / EX boundary ----
  // A flush loads a bubble: all control zero so it can never redirect,
  // and a canonical NOP in the instruction field.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      PC_EX          <= '0;
      PC_plus_4_EX   <= '0;
      INST_EX        <= '0;
      rs1_EX         <= '0;
      rs2_EX         <= '0;
      rd_EX          <= '0;
      imm_EX         <= '0;
      RD1D_EX        <= '0;
      RD2D_EX        <= '0;
      reg_write_EX   <= 1'b0;
      mem_write_EX   <= 1'b0;
      meet_branch_EX <= 1'b0;
      pc_jal_sel_EX  <= 1'b0;
      result_sel_EX  <= '0;
      uncond_jump_EX <= JUMP_NONE;
      alu_sel_rs1_EX <= SEL_A_RS1;
      alu_sel_rs2_EX <= SEL_B_RS2;
      alu_ctrl_EX    <= ALU_ADD;
      funct3_EX      <= '0;
    end else if (bus.flush_ID_EX) begin
      PC_EX          <= '0;
      PC_plus_4_EX   <= '0;
      INST_EX        <= NOP_INST;
      rs1_EX         <= '0;
      rs2_EX         <= '0;
      rd_EX          <= '0;
      imm_EX         <= '0;
      RD1D_EX        <= '0;
      RD2D_EX        <= '0;
      reg_write_EX   <= 1'b0;
      mem_write_EX   <= 1'b0;
      meet_branch_EX <= 1'b0;
      pc_jal_sel_EX  <= 1'b0;
      result_sel_EX  <= '0;
      uncond_jump_EX <= JUMP_NONE;
      alu_sel_rs1_EX <= SEL_A_RS1;
      alu_sel_rs2_EX <= SEL_B_RS2;
      alu_ctrl_EX    <= ALU_ADD;
      funct3_EX      <= '0;
    end else begin
      PC_EX          <= bus.PC_ID;
      PC_plus_4_EX   <= bus.PC_plus_4_ID;
      INST_EX        <= bus.INST_ID;
      rs1_EX         <= bus.rs1_ID;
      rs2_EX         <= bus.rs2_ID;
      rd_EX          <= bus.rd_ID;
      imm_EX         <= bus.imm_ID;
      RD1D_EX        <= bus.RD1D_ID;
      RD2D_EX        <= bus.RD2D_ID;
      reg_write_EX   <= bus.reg_write_ID;
      mem_write_EX   <= bus.mem_write_ID;
      meet_branch_EX <= bus.meet_branch_ID;
      pc_jal_sel_EX  <= bus.pc_jal_sel_ID;
      result_sel_EX  <= bus.result_sel_ID;
      uncond_jump_EX <= bus.uncond_jump_ID;
      alu_sel_rs1_EX <= bus.alu_sel_rs1_ID;
      alu_sel_rs2_EX <= bus.alu_sel_rs2_ID;
      alu_ctrl_EX    <= bus.alu_ctrl_ID;
      funct3_EX      <= bus.funct3_ID;
    end
  end

  // ---- EX combinational datapath ----
  always_comb begin
    case (bus.forward_detect_rs1)
      FWD_MEM: rs1_fwd = bus.alu_res_MEM;
      FWD_WB:  rs1_fwd = bus.result_WB;
      default: rs1_fwd = RD1D_EX;
    endcase
    case (bus.forward_detect_rs2)
      FWD_MEM: rs2_fwd = bus.alu_res_MEM;
      FWD_WB:  rs2_fwd = bus.result_WB;
      default: rs2_fwd = RD2D_EX;
    endcase
  end

  always_comb begin
    case (alu_sel_rs1_EX)
      SEL_A_RS1: alu_op_a = rs1_fwd;
      SEL_A_PC:  alu_op_a = PC_EX;
      default:   alu_op_a = '0;
    endcase
    case (alu_sel_rs2_EX)
      SEL_B_RS2: alu_op_b = rs2_fwd;
      SEL_B_IMM: alu_op_b = imm_EX;
      default:   alu_op_b = DATA_WIDTH'(4);
    endcase
  end

  ex_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op_a     (alu_op_a),
    .op_b     (alu_op_b),
    .alu_ctrl (alu_ctrl_EX),
    .result   (alu_res_EX)
  );

  always_comb begin
    case (funct3_EX)
      BR_EQ:   br_cond = (rs1_fwd == rs2_fwd);
      BR_NE:   br_cond = (rs1_fwd != rs2_fwd);
      BR_LT:   br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      BR_GE:   br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      BR_LTU:  br_cond = (rs1_fwd <  rs2_fwd);
      BR_GEU:  br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
  end

  // Exact compares make uncond_jump 2'b11 behave like JUMP_NONE.
  assign jalr_sum                    = rs1_fwd + imm_EX;
  assign bus.PC_take_branch_EX       = (meet_branch_EX & br_cond) |
                                       (uncond_jump_EX == JUMP_JAL);
  assign bus.PC_take_jalr_EX         = (uncond_jump_EX == JUMP_JALR);
  assign bus.PC_for_normal_branch_EX = PC_EX + imm_EX;
  assign bus.PC_for_jalr_EX          = jalr_sum & {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  assign bus.rs1_EX        = rs1_EX;
  assign bus.rs2_EX        = rs2_EX;
  assign bus.rd_EX         = rd_EX;
  assign bus.result_sel_EX = result_sel_EX;

  // ---- EX / MEM boundary ----
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      bus.INST_MEM       <= '0;
      bus.reg_write_MEM  <= 1'b0;
      bus.mem_write_MEM  <= 1'b0;
      bus.result_sel_MEM <= '0;
      bus.alu_res_MEM_o  <= '0;
      bus.write_data_MEM <= '0;
      bus.PC_plus_4_MEM  <= '0;
      bus.rd_MEM         <= '0;
      bus.funct3_MEM     <= '0;
    end else begin
      bus.INST_MEM       <= INST_EX;
      bus.reg_write_MEM  <= reg_write_EX;
      bus.mem_write_MEM  <= mem_write_EX;
      bus.result_sel_MEM <= result_sel_EX;
      bus.alu_res_MEM_o  <= alu_res_EX;
      bus.write_data_MEM <= rs2_fwd;
      bus.PC_plus_4_MEM  <= PC_plus_4_EX;
      bus.rd_MEM         <= rd_EX;
      bus.funct3_MEM     <= funct3_EX;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ex_stage_if bus_if ();

  ex_stage dut (
    .cpu_clk (clk),
    .cpu_rst (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] pc, inst, imm, rd1, rd2, alu_mem, res_wb;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_write, meet_branch, pc_jal_sel;
    logic [1:0]  result_sel, uncond, sel_a, sel_b;
    logic [3:0]  alu_ctrl;
    logic [2:0]  funct3, fwd1, fwd2;
  } txn_t;

  function automatic txn_t blank_txn();
    txn_t t = '{default: '0};
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.flush       = 1'b0;
    t.pc          = $urandom & 32'hFFFF_FFFC;
    t.inst        = $urandom;
    t.imm         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
    t.rd1         = $urandom;
    t.rd2         = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
    t.alu_mem     = $urandom;
    t.res_wb      = $urandom;
    t.rs1         = 5'($urandom);
    t.rs2         = 5'($urandom);
    t.rd          = 5'($urandom);
    t.reg_write   = 1'($urandom);
    t.mem_write   = 1'($urandom);
    t.meet_branch = 1'($urandom);
    t.pc_jal_sel  = 1'($urandom);
    t.result_sel  = 2'($urandom);
    t.uncond      = 2'($urandom);
    t.sel_a       = 2'($urandom);
    t.sel_b       = 2'($urandom);
    t.alu_ctrl    = 4'($urandom_range(0, 12));
    t.funct3      = 3'($urandom);
    t.fwd1        = 3'($urandom);
    t.fwd2        = 3'($urandom);
    return t;
  endfunction

  // What ID/EX holds after a flush: a zeroed NOP. The forwarding-side
  // inputs are not part of ID/EX, so they are kept from the driven step.
  function automatic txn_t bubble_of(input txn_t t);
    txn_t b = blank_txn();
    b.inst    = 32'h0000_0013;
    b.fwd1    = t.fwd1;
    b.fwd2    = t.fwd2;
    b.alu_mem = t.alu_mem;
    b.res_wb  = t.res_wb;
    return b;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_ref(input logic [2:0] sel, input logic [31:0] regv,
                                          input logic [31:0] memv, input logic [31:0] wbv);
    if (sel == 3'd1) return memv;
    if (sel == 3'd2) return wbv;
    return regv;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] op_a_ref(input txn_t t);
    if (t.sel_a == 2'd0) return fwd_ref(t.fwd1, t.rd1, t.alu_mem, t.res_wb);
    if (t.sel_a == 2'd1) return t.pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] op_b_ref(input txn_t t);
    if (t.sel_b == 2'd0) return fwd_ref(t.fwd2, t.rd2, t.alu_mem, t.res_wb);
    if (t.sel_b == 2'd1) return t.imm;
    return 32'd4;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input txn_t t);
    bus_if.flush_ID_EX        = t.flush;
    bus_if.PC_ID              = t.pc;
    bus_if.PC_plus_4_ID       = t.pc + 32'd4;
    bus_if.INST_ID            = t.inst;
    bus_if.rs1_ID             = t.rs1;
    bus_if.rs2_ID             = t.rs2;
    bus_if.rd_ID              = t.rd;
    bus_if.imm_ID             = t.imm;
    bus_if.RD1D_ID            = t.rd1;
    bus_if.RD2D_ID            = t.rd2;
    bus_if.reg_write_ID       = t.reg_write;
    bus_if.mem_write_ID       = t.mem_write;
    bus_if.meet_branch_ID     = t.meet_branch;
    bus_if.pc_jal_sel_ID      = t.pc_jal_sel;
    bus_if.result_sel_ID      = t.result_sel;
    bus_if.uncond_jump_ID     = t.uncond;
    bus_if.alu_sel_rs1_ID     = t.sel_a;
    bus_if.alu_sel_rs2_ID     = t.sel_b;
    bus_if.alu_ctrl_ID        = t.alu_ctrl;
    bus_if.funct3_ID          = t.funct3;
    bus_if.forward_detect_rs1 = t.fwd1;
    bus_if.forward_detect_rs2 = t.fwd2;
    bus_if.alu_res_MEM        = t.alu_mem;
    bus_if.result_WB          = t.res_wb;
  endtask

  task automatic check_ex(input txn_t e, input string tag);
    logic [31:0] r1, r2;
    logic        take_br, take_jalr;
    r1        = fwd_ref(e.fwd1, e.rd1, e.alu_mem, e.res_wb);
    r2        = fwd_ref(e.fwd2, e.rd2, e.alu_mem, e.res_wb);
    take_br   = (e.meet_branch && br_ref(e.funct3, r1, r2)) || (e.uncond == 2'b01);
    take_jalr = (e.uncond == 2'b10);
    check({tag, ".take_br"},    32'(bus_if.PC_take_branch_EX), 32'(take_br));
    check({tag, ".br_target"},  bus_if.PC_for_normal_branch_EX, e.pc + e.imm);
    check({tag, ".take_jalr"},  32'(bus_if.PC_take_jalr_EX), 32'(take_jalr));
    check({tag, ".jalr_tgt"},   bus_if.PC_for_jalr_EX, (r1 + e.imm) & 32'hFFFF_FFFE);
    check({tag, ".rs1_EX"},     32'(bus_if.rs1_EX), 32'(e.rs1));
    check({tag, ".rs2_EX"},     32'(bus_if.rs2_EX), 32'(e.rs2));
    check({tag, ".rd_EX"},      32'(bus_if.rd_EX), 32'(e.rd));
    check({tag, ".rsel_EX"},    32'(bus_if.result_sel_EX), 32'(e.result_sel));
  endtask

  task automatic check_mem(input txn_t e, input string tag);
    check({tag, ".inst_MEM"},   bus_if.INST_MEM, e.inst);
    check({tag, ".rw_MEM"},     32'(bus_if.reg_write_MEM), 32'(e.reg_write));
    check({tag, ".mw_MEM"},     32'(bus_if.mem_write_MEM), 32'(e.mem_write));
    check({tag, ".rsel_MEM"},   32'(bus_if.result_sel_MEM), 32'(e.result_sel));
    check({tag, ".alu_MEM"},    bus_if.alu_res_MEM_o, alu_ref(e.alu_ctrl, op_a_ref(e), op_b_ref(e)));
    check({tag, ".wdata_MEM"},  bus_if.write_data_MEM, fwd_ref(e.fwd2, e.rd2, e.alu_mem, e.res_wb));
    check({tag, ".pc4_MEM"},    bus_if.PC_plus_4_MEM, e.flush ? 32'd0 : e.pc + 32'd4);
    check({tag, ".rd_MEM"},     32'(bus_if.rd_MEM), 32'(e.rd));
    check({tag, ".f3_MEM"},     32'(bus_if.funct3_MEM), 32'(e.funct3));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".inst_MEM"},  bus_if.INST_MEM, 32'd0);
    check({tag, ".rw_MEM"},    32'(bus_if.reg_write_MEM), 32'd0);
    check({tag, ".mw_MEM"},    32'(bus_if.mem_write_MEM), 32'd0);
    check({tag, ".rsel_MEM"},  32'(bus_if.result_sel_MEM), 32'd0);
    check({tag, ".alu_MEM"},   bus_if.alu_res_MEM_o, 32'd0);
    check({tag, ".wdata_MEM"}, bus_if.write_data_MEM, 32'd0);
    check({tag, ".pc4_MEM"},   bus_if.PC_plus_4_MEM, 32'd0);
    check({tag, ".rd_MEM"},    32'(bus_if.rd_MEM), 32'd0);
    check({tag, ".f3_MEM"},    32'(bus_if.funct3_MEM), 32'd0);
    check({tag, ".take_br"},   32'(bus_if.PC_take_branch_EX), 32'd0);
    check({tag, ".take_jalr"}, 32'(bus_if.PC_take_jalr_EX), 32'd0);
  endtask

  // Drive one instruction and hold it (with its forwarding inputs) for two
  // edges: EX outputs are checked after the first, MEM outputs after the second.
  task automatic run(input txn_t t, input string tag);
    txn_t e;
    e = t.flush ? bubble_of(t) : t;
    if (t.flush) e.flush = 1'b1;
    drive(t);
    @(posedge clk); #1;
    check_ex(e, tag);
    @(posedge clk); #1;
    check_mem(e, tag);
  endtask

  initial begin
    txn_t t;
    errors = 0;
    checks = 0;

    // reset state
    rst = 1'b1;
    t = blank_txn();
    t.inst = 32'hDEAD_BEEF; t.rd1 = 32'h1234; t.reg_write = 1'b1; t.uncond = 2'b01;
    drive(t);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // ADD with rs1 forwarded from MEM
    t = blank_txn();
    t.rd1 = 32'd1; t.alu_mem = 32'd5; t.fwd1 = 3'b001; t.rd2 = 32'd7;
    t.alu_ctrl = 4'd0; t.rd = 5'd3; t.reg_write = 1'b1; t.inst = 32'h0020_81B3;
    run(t, "add_fwd_rs1");
    check("add_fwd_rs1.value", bus_if.alu_res_MEM_o, 32'd12);

    // rs2 forwarded from WB
    t = blank_txn();
    t.rd1 = 32'd2; t.rd2 = 32'd100; t.res_wb = 32'd9; t.fwd2 = 3'b010;
    t.mem_write = 1'b1; t.funct3 = 3'b010;
    run(t, "fwd_rs2_wb");
    check("fwd_rs2_wb.value", bus_if.write_data_MEM, 32'd9);

    // BLT signed: -1 < 1
    t = blank_txn();
    t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; t.funct3 = 3'b100; t.meet_branch = 1'b1;
    t.pc = 32'h100; t.imm = 32'hFFFF_FFF8;
    run(t, "blt");
    check("blt.take", 32'(bus_if.PC_take_branch_EX), 32'd1);
    check("blt.target", bus_if.PC_for_normal_branch_EX, 32'h0000_00F8);

    // BLTU: 0xFFFFFFFF is not below 1
    t.funct3 = 3'b110;
    run(t, "bltu");
    check("bltu.take", 32'(bus_if.PC_take_branch_EX), 32'd0);

    // JALR clears bit 0 of the target
    t = blank_txn();
    t.rd1 = 32'h203; t.imm = 32'd4; t.uncond = 2'b10;
    run(t, "jalr");
    check("jalr.take", 32'(bus_if.PC_take_jalr_EX), 32'd1);
    check("jalr.target", bus_if.PC_for_jalr_EX, 32'h0000_0206);

    // uncond_jump 2'b11 acts like no jump
    t = blank_txn();
    t.uncond = 2'b11; t.rd1 = 32'd5; t.rd2 = 32'd6; t.meet_branch = 1'b1;
    run(t, "jump11");

    // flush: a JAL with reg_write becomes a non-redirecting NOP
    t = blank_txn();
    t.flush = 1'b1; t.reg_write = 1'b1; t.uncond = 2'b01; t.pc = 32'h400;
    t.inst = 32'h0080_00EF; t.rd = 5'd1;
    run(t, "flush");
    check("flush.take", 32'(bus_if.PC_take_branch_EX), 32'd0);
    check("flush.nop", bus_if.INST_MEM, 32'h0000_0013);
    check("flush.rw", 32'(bus_if.reg_write_MEM), 32'd0);

    // ALU sweep with A=0x80000000, B=1
    for (int op = 0; op < 16; op++) begin
      t = blank_txn();
      t.rd1 = 32'h8000_0000; t.sel_b = 2'd1; t.imm = 32'd1; t.alu_ctrl = 4'(op);
      run(t, $sformatf("sweep%0d", op));
      case (op)
        1: check("sweep.sub",  bus_if.alu_res_MEM_o, 32'h7FFF_FFFF);
        3: check("sweep.slt",  bus_if.alu_res_MEM_o, 32'd1);
        4: check("sweep.sltu", bus_if.alu_res_MEM_o, 32'd0);
        6: check("sweep.srl",  bus_if.alu_res_MEM_o, 32'h4000_0000);
        7: check("sweep.sra",  bus_if.alu_res_MEM_o, 32'hC000_0000);
        default: ;
      endcase
    end

    // randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      t = rand_txn();
      run(t, $sformatf("rand%0d", i));
    end

    // reset asserted mid-cycle with live, redirecting contents
    t = rand_txn();
    t.uncond = 2'b01; t.reg_write = 1'b1; t.inst = 32'hCAFE_0001; t.rd = 5'd7;
    t.funct3 = 3'b101; t.result_sel = 2'd2; t.pc = 32'h0000_1000;
    run(t, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
